// File: rtl/hex_digits_scan_driver_if.sv
// Bundle between the hex-digits PIO side and the 7-segment bank pins.
// The PIO side supplies the value and the blanking request; the scan driver
// returns the active-low segment/digit drives and the frame capture pulse.
interface hex_digits_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] hex_value;
  logic                    blank_lz;
  logic [6:0]              hex_seg_n;
  logic [NUM_DIGITS-1:0]   digit_en_n;
  logic                    frame_tick;

  // Value source: drives the value and the blanking request, watches the pins
  modport master (
    output hex_value,
    output blank_lz,
    input  hex_seg_n,
    input  digit_en_n,
    input  frame_tick
  );

  // Scan driver: consumes the value, drives the pins
  modport slave (
    input  hex_value,
    input  blank_lz,
    output hex_seg_n,
    output digit_en_n,
    output frame_tick
  );

endinterface

// File: rtl/hex_digits_scan_driver.sv
// Time-multiplexed driver for a common-anode 7-segment bank.
// The PIO value is copied into a shadow register only at the frame boundary
// (last cycle of the last digit slot), so a frame never mixes old and new
// digits. Each digit slot begins with one dead cycle where every digit and
// segment is off, which removes ghosting while the anode switches over.
// All pin outputs are registered from the scan state, one cycle behind it.
module hex_digits_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  hex_digits_scan_driver_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HEX_W = 4 * NUM_DIGITS;

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] EN_OFF   = {NUM_DIGITS{1'b1}};

  // Nibble to active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [HEX_W-1:0]      shadow_q, shadow_d;
  logic                  blank_q, blank_d;

  // Registered pin drives
  logic [6:0]            hex_seg_q, hex_seg_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;
  logic                  frame_tick_q, frame_tick_d;

  // Combinational helpers
  logic                  slot_end_s;
  logic                  frame_end_s;
  logic                  dead_s;
  logic                  blanked_s;
  logic [3:0]            cur_nib_s;
  logic [NUM_DIGITS-1:0] upper_zero_s;

  // Slot and frame boundary detection
  always_comb begin
    slot_end_s  = (div_cnt_q == DIV_LAST);
    frame_end_s = slot_end_s && (idx_q == IDX_LAST);
    dead_s      = (div_cnt_q == {DIV_W{1'b0}});
  end

  // Divider and digit index advance; index wraps after the last digit
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    if (slot_end_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Shadow capture of value and blanking mode, only at the frame boundary
  always_comb begin
    shadow_d     = shadow_q;
    blank_d      = blank_q;
    frame_tick_d = frame_end_s;
    if (frame_end_s) begin
      shadow_d = bus.hex_value;
      blank_d  = bus.blank_lz;
    end else begin
      shadow_d = shadow_q;
      blank_d  = blank_q;
    end
  end

  // upper_zero_s[i] is set when nibbles i..NUM_DIGITS-1 of the shadow are all zero
  always_comb begin
    logic run_zero;
    run_zero     = 1'b1;
    upper_zero_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero        = run_zero && (shadow_q[4*i +: 4] == 4'h0);
      upper_zero_s[i] = run_zero;
    end
  end

  // Current digit nibble and leading-zero blanking decision (digit 0 always shown)
  always_comb begin
    cur_nib_s = shadow_q[{idx_q, 2'b00} +: 4];
    blanked_s = blank_q && (idx_q != {IDX_W{1'b0}}) && upper_zero_s[idx_q];
  end

  // Next pin drives: dark on the dead cycle and on blanked digits, else one anode low
  always_comb begin
    hex_seg_d    = SEG_OFF;
    digit_en_n_d = EN_OFF;
    if (dead_s || blanked_s) begin
      hex_seg_d    = SEG_OFF;
      digit_en_n_d = EN_OFF;
    end else begin
      hex_seg_d    = seg_decode(cur_nib_s);
      digit_en_n_d = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= {DIV_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      shadow_q     <= {HEX_W{1'b0}};
      blank_q      <= 1'b0;
      hex_seg_q    <= SEG_OFF;
      digit_en_n_q <= EN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      blank_q      <= blank_d;
      hex_seg_q    <= hex_seg_d;
      digit_en_n_q <= digit_en_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.hex_seg_n  = hex_seg_q;
  assign bus.digit_en_n = digit_en_n_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_digits_scan_driver.sv
// Directed and randomised bench for hex_digits_scan_driver with
// NUM_DIGITS=4 and SCAN_DIV=4 (16-cycle frames).
module tb_hex_digits_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  localparam logic [6:0] DEC_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic reset = 1'b1;

  hex_digits_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  hex_digits_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] seg_log  [1:16];
  logic [3:0] en_log   [1:16];
  logic       tick_log [1:16];

  // Advance to the next cycle showing frame_tick, bounded
  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 40);
    n_checks++;
    if (bus.frame_tick !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: frame_tick got %b after %0d cycles, expected 1 within 40", name, bus.frame_tick, n);
    end
  endtask

  // Record the 16 cycles following the current one; optionally change hex_value at chg_off
  task automatic capture_frame(input int chg_off, input logic [15:0] chg_val);
    for (int off = 1; off <= 16; off++) begin
      @(negedge clk);
      seg_log[off]  = bus.hex_seg_n;
      en_log[off]   = bus.digit_en_n;
      tick_log[off] = bus.frame_tick;
      if (off == chg_off) bus.hex_value = chg_val;
    end
  endtask

  task automatic test_reset();
    int n;
    bus.hex_value = 16'h12AF;
    bus.blank_lz  = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.hex_seg_n, bus.digit_en_n, bus.frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
        n_errors++;
        $display("FAIL reset_state cyc=%0d: got seg=%h en=%h tick=%b, expected seg=7f en=f tick=0",
                 c, bus.hex_seg_n, bus.digit_en_n, bus.frame_tick);
      end
    end
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 40);
    n_checks++;
    if (n != 16 || bus.frame_tick !== 1'b1) begin
      n_errors++;
      $display("FAIL first_tick: got tick=%b after %0d cycles, expected 1 after 16", bus.frame_tick, n);
    end
  endtask

  task automatic test_decode();
    logic [6:0] es [4];
    logic [3:0] ee [4];
    logic [6:0] xs;
    logic [3:0] xe;
    es = '{7'h0E, 7'h08, 7'h24, 7'h79};
    ee = '{4'hE, 4'hD, 4'hB, 4'h7};
    bus.hex_value = 16'h12AF;
    bus.blank_lz  = 1'b0;
    wait_tick("decode_tick");
    capture_frame(0, 16'h0000);
    for (int off = 1; off <= 16; off++) begin
      xs = (((off - 1) % 4) == 0) ? 7'h7F : es[(off - 1) / 4];
      xe = (((off - 1) % 4) == 0) ? 4'hF  : ee[(off - 1) / 4];
      n_checks++;
      if ({seg_log[off], en_log[off], tick_log[off]} !== {xs, xe, (off == 16)}) begin
        n_errors++;
        $display("FAIL decode_12AF off=%0d: got seg=%h en=%h tick=%b, expected seg=%h en=%h tick=%b",
                 off, seg_log[off], en_log[off], tick_log[off], xs, xe, (off == 16));
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] es [4];
    logic [3:0] ee [4];
    logic [15:0] vals [2];
    logic [6:0] xs;
    logic [3:0] xe;
    vals = '{16'h00A0, 16'h0000};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        es = '{7'h40, 7'h08, 7'h7F, 7'h7F};
        ee = '{4'hE, 4'hD, 4'hF, 4'hF};
      end else begin
        es = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        ee = '{4'hE, 4'hF, 4'hF, 4'hF};
      end
      bus.hex_value = vals[k];
      bus.blank_lz  = 1'b1;
      wait_tick("blank_tick");
      capture_frame(0, 16'h0000);
      for (int off = 1; off <= 16; off++) begin
        xs = (((off - 1) % 4) == 0) ? 7'h7F : es[(off - 1) / 4];
        xe = (((off - 1) % 4) == 0) ? 4'hF  : ee[(off - 1) / 4];
        n_checks++;
        if ({seg_log[off], en_log[off], tick_log[off]} !== {xs, xe, (off == 16)}) begin
          n_errors++;
          $display("FAIL blank_%h off=%0d: got seg=%h en=%h tick=%b, expected seg=%h en=%h tick=%b",
                   vals[k], off, seg_log[off], en_log[off], tick_log[off], xs, xe, (off == 16));
        end
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [6:0] es [2][4];
    logic [3:0] ee [4];
    logic [6:0] xs;
    logic [3:0] xe;
    es[0] = '{7'h19, 7'h30, 7'h24, 7'h79};
    es[1] = '{7'h00, 7'h78, 7'h02, 7'h12};
    ee = '{4'hE, 4'hD, 4'hB, 4'h7};
    bus.hex_value = 16'h1234;
    bus.blank_lz  = 1'b0;
    wait_tick("tear_tick");
    for (int k = 0; k < 2; k++) begin
      if (k == 0) capture_frame(6, 16'h5678);
      else        capture_frame(0, 16'h0000);
      for (int off = 1; off <= 16; off++) begin
        xs = (((off - 1) % 4) == 0) ? 7'h7F : es[k][(off - 1) / 4];
        xe = (((off - 1) % 4) == 0) ? 4'hF  : ee[(off - 1) / 4];
        n_checks++;
        if ({seg_log[off], en_log[off], tick_log[off]} !== {xs, xe, (off == 16)}) begin
          n_errors++;
          $display("FAIL no_tearing frame=%0d off=%0d: got seg=%h en=%h tick=%b, expected seg=%h en=%h tick=%b",
                   k, off, seg_log[off], en_log[off], tick_log[off], xs, xe, (off == 16));
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] ee [4];
    logic [6:0] xs;
    logic [3:0] xe;
    ee = '{4'hE, 4'hD, 4'hB, 4'h7};
    // Now at a frame_tick cycle showing 5678; move into the digit 2 slot
    repeat (9) @(negedge clk);
    bus.blank_lz = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.hex_seg_n, bus.digit_en_n, bus.frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
      n_errors++;
      $display("FAIL mid_reset: got seg=%h en=%h tick=%b, expected seg=7f en=f tick=0",
               bus.hex_seg_n, bus.digit_en_n, bus.frame_tick);
    end
    reset = 1'b0;
    capture_frame(0, 16'h0000);
    // Shadow cleared and blanking off: every digit shows "0"
    for (int off = 1; off <= 16; off++) begin
      xs = (((off - 1) % 4) == 0) ? 7'h7F : 7'h40;
      xe = (((off - 1) % 4) == 0) ? 4'hF  : ee[(off - 1) / 4];
      n_checks++;
      if ({seg_log[off], en_log[off], tick_log[off]} !== {xs, xe, (off == 16)}) begin
        n_errors++;
        $display("FAIL after_mid_reset off=%0d: got seg=%h en=%h tick=%b, expected seg=%h en=%h tick=%b",
                 off, seg_log[off], en_log[off], tick_log[off], xs, xe, (off == 16));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] cur_v, new_v;
    logic        cur_b, new_b;
    logic [3:0]  nib;
    logic        blk;
    logic [6:0]  xs;
    logic [3:0]  xe;
    int          d;
    // Value captured at the last boundary: 5678 with blanking requested
    cur_v = 16'h5678;
    cur_b = 1'b1;
    for (int f = 0; f < 200; f++) begin
      new_v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      new_b = 1'($urandom_range(0, 1));
      bus.hex_value = new_v;
      bus.blank_lz  = new_b;
      for (int off = 1; off <= 16; off++) begin
        @(negedge clk);
        d   = (off - 1) / 4;
        nib = 4'((cur_v >> (4 * d)) & 16'h000F);
        blk = cur_b && (d > 0) && ((cur_v >> (4 * d)) == 16'h0000);
        if (((off - 1) % 4) == 0 || blk) begin
          xs = 7'h7F;
          xe = 4'hF;
        end else begin
          xs = DEC_TAB[nib];
          xe = ~(4'b0001 << d);
        end
        n_checks++;
        if ({bus.hex_seg_n, bus.digit_en_n, bus.frame_tick} !== {xs, xe, (off == 16)}) begin
          n_errors++;
          $display("FAIL random frame=%0d val=%h blk=%b off=%0d: got seg=%h en=%h tick=%b, expected seg=%h en=%h tick=%b",
                   f, cur_v, cur_b, off, bus.hex_seg_n, bus.digit_en_n, bus.frame_tick, xs, xe, (off == 16));
        end
        n_checks++;
        if ($countones(~bus.digit_en_n) > 1) begin
          n_errors++;
          $display("FAIL onehot frame=%0d off=%0d: got en=%h, expected at most one low bit",
                   f, off, bus.digit_en_n);
        end
      end
      cur_v = new_v;
      cur_b = new_b;
    end
  endtask

  initial begin
    bus.hex_value = 16'h0000;
    bus.blank_lz  = 1'b0;
    test_reset();
    test_decode();
    test_blanking();
    test_no_tearing();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
